// File: rtl/regfile_p.sv
// regfile_p: parameterised register file with two combinational read ports,
// one write port and a handshaked serial dump of every register.
// Optional build macro: REGFILE_BYPASS_EN. When it is defined, a write is forwarded
// to a read port whose address matches the write address in the same cycle.
// The dump port never forwards; it always shows the stored contents.
//
// Dump FSM
//   state | meaning
//   IDLE  | no dump active, dump outputs held at zero
//   RUN   | presenting register dump_ptr_q, advancing on each accepted word
module regfile_p #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 32,
    parameter int ZERO_R0 = 1,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              We,
    input  logic [ADDR_W-1:0] Wa,
    input  logic [WIDTH-1:0]  Wd,
    input  logic [ADDR_W-1:0] Ra1,
    input  logic [ADDR_W-1:0] Ra2,
    output logic [WIDTH-1:0]  Rd1,
    output logic [WIDTH-1:0]  Rd2,
    input  logic              Dump_Start,
    input  logic              Dump_Ready,
    output logic              Dump_Valid,
    output logic [ADDR_W-1:0] Dump_Addr,
    output logic [WIDTH-1:0]  Dump_Data,
    output logic              Dump_Last,
    output logic              Dump_Busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dump_state_t;

    localparam logic [ADDR_W-1:0] LAST_A     = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PRE_LAST_A = ADDR_W'(DEPTH - 2);

    logic [WIDTH-1:0]  regs_q [DEPTH];
    dump_state_t       state_q;
    logic [ADDR_W-1:0] dump_ptr_q;
    logic              dump_last_q;
    logic              wr_en;

    // Address 0 is read-only zero when ZERO_R0 is set, so those writes are dropped.
    assign wr_en = We && !Clr && !((ZERO_R0 != 0) && (Wa == '0));

    function automatic logic [WIDTH-1:0] read_reg(input logic [ADDR_W-1:0] addr);
        if ((ZERO_R0 != 0) && (addr == '0))
            return '0;
        return regs_q[addr];
    endfunction

    // Register storage: synchronous clear has priority over writes.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[Wa] <= Wd;
        end
    end

    // Read ports: zero latency, optional same-cycle write forwarding.
`ifdef REGFILE_BYPASS_EN
    assign Rd1 = (wr_en && (Ra1 == Wa)) ? Wd : read_reg(Ra1);
    assign Rd2 = (wr_en && (Ra2 == Wa)) ? Wd : read_reg(Ra2);
`else
    assign Rd1 = read_reg(Ra1);
    assign Rd2 = read_reg(Ra2);
`endif

    // Dump sequencer: walks the pointer 0..DEPTH-1, one step per accepted word.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q     <= IDLE;
            dump_ptr_q  <= '0;
            dump_last_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    dump_ptr_q  <= '0;
                    dump_last_q <= 1'b0;
                    if (Dump_Start)
                        state_q <= RUN;
                end
                RUN: begin
                    if (Dump_Ready) begin
                        if (dump_ptr_q == LAST_A) begin
                            state_q     <= IDLE;
                            dump_ptr_q  <= '0;
                            dump_last_q <= 1'b0;
                        end else begin
                            dump_ptr_q  <= dump_ptr_q + 1'b1;
                            dump_last_q <= (dump_ptr_q == PRE_LAST_A);
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    dump_ptr_q  <= '0;
                    dump_last_q <= 1'b0;
                end
            endcase
        end
    end

    assign Dump_Busy  = (state_q == RUN);
    assign Dump_Valid = (state_q == RUN);
    assign Dump_Addr  = dump_ptr_q;
    assign Dump_Last  = dump_last_q;
    // Data follows the stored word so writes during a stall show up before acceptance.
    assign Dump_Data  = (state_q == RUN) ? read_reg(dump_ptr_q) : '0;

endmodule

// File: doc/regfile_p.md
REGFILE_P -- requirements
Module: regfile_p

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per register.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers; power of two, >= 2.
REQ-003 SHALL have parameter ZERO_R0, default 1, register 0 hardwired to zero when 1.
REQ-004 SHALL derive ADDR_W = log2(DEPTH), not user-set.
REQ-005 SHALL have ports: Clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have: Clr  in  1  synchronous active-high reset.
REQ-007 SHALL have: We  in  1  write enable; Wa  in  ADDR_W  write address; Wd  in  WIDTH  write data.
REQ-008 SHALL have: Ra1, Ra2  in  ADDR_W  read addresses; Rd1, Rd2  out  WIDTH  read data.
REQ-009 SHALL have: Dump_Start  in  1  request serial readout of all registers.
REQ-010 SHALL have: Dump_Ready  in  1  consumer accepts current dump word.
REQ-011 SHALL have: Dump_Valid  out  1; Dump_Addr  out  ADDR_W; Dump_Data  out  WIDTH; Dump_Last  out  1; Dump_Busy  out  1.

Function
REQ-012 SHALL write Wd into register Wa at rising Clk when We=1 and Clr=0, except Wa=0 with ZERO_R0=1 (write discarded).
REQ-013 SHALL drive Rd1/Rd2 combinationally from registers Ra1/Ra2; zero latency; both ports independent, same address allowed.
REQ-014 SHALL return 0 on any read or dump of address 0 when ZERO_R0=1, regardless of prior writes.
REQ-015 SHALL implement dump FSM with states IDLE and RUN; Dump_Busy=1 exactly in RUN.
REQ-016 SHALL move IDLE->RUN on rising Clk with Dump_Start=1, dump pointer loaded to 0; Dump_Start ignored in RUN.
REQ-017 SHALL, in RUN, hold Dump_Valid=1, Dump_Addr=pointer, Dump_Data=current stored contents of register pointer (no bypass).
REQ-018 SHALL complete a transfer on a rising edge with Dump_Valid=1 and Dump_Ready=1; pointer increments by 1.
REQ-019 SHALL hold Dump_Addr stable while Dump_Ready=0; Dump_Data tracks writes to that address during stall.
REQ-020 SHALL assert Dump_Last when in RUN and pointer = DEPTH-1; transfer of that word returns FSM to IDLE next cycle; no wrap.
REQ-021 SHALL keep normal writes/reads fully functional during RUN; a write to pointer address on the transfer edge is not reflected in the transferred word.
REQ-022 SHALL drive Dump_Valid=0, Dump_Last=0, Dump_Addr=0, Dump_Data=0 in IDLE.
REQ-023 SHALL accept Dump_Start on the same edge the previous dump's last transfer completes only after returning to IDLE (one idle cycle minimum between dumps).

Reset
REQ-024 SHALL, on rising Clk with Clr=1, clear every register to 0, force IDLE, pointer to 0; Clr priority over We and Dump_Start.
REQ-025 SHALL, with Clr=1 mid-dump, abort: Dump_Valid=0, Dump_Busy=0 from the next cycle; no partial resume.
REQ-026 SHALL present after reset: Rd1=Rd2=0 for all addresses, Dump_Valid=Dump_Last=Dump_Busy=0.

Configuration
REQ-027 SHALL, with macro REGFILE_BYPASS_EN defined, forward Wd to Rd1/Rd2 when We=1, Clr=0, write not discarded per REQ-012, and Ra equals Wa.
REQ-028 SHALL, without REGFILE_BYPASS_EN, return old stored value on same-cycle read-during-write; new value visible after the edge.

Verification
REQ-029 SHALL cover: Clr 1 cycle, then Ra1=5, Ra2=31 -> Rd1=Rd2=0, Dump_Busy=0.
REQ-030 SHALL cover: write Wa=0 Wd=32'hDEADBEEF then Ra1=0 -> Rd1=0 (ZERO_R0=1); with ZERO_R0=0 -> 32'hDEADBEEF.
REQ-031 SHALL cover: We=1 Wa=7 Wd=32'h12345678, Ra1=7 same cycle -> Rd1=32'h12345678 with REGFILE_BYPASS_EN, prior value (0) without; both 32'h12345678 next cycle.
REQ-032 SHALL cover: regs i=1..31 loaded with i*16'h0101, Dump_Start, Dump_Ready=1 -> 32 words addr 0..31, word 3 = 32'h0303, Dump_Last only on addr 31, Busy drops next cycle.
REQ-033 SHALL cover: dump with Dump_Ready=0 for 3 cycles at addr 4 while writing 32'hA5A5A5A5 to reg 4 -> Dump_Addr stays 4, accepted word = 32'hA5A5A5A5.
REQ-034 SHALL cover: Clr asserted at dump addr 10 -> Dump_Valid=0 next cycle, all registers 0, new Dump_Start restarts at addr 0.
